// File: rtl/mc_controller_hs_pkg.sv
// Shared types and constants for the multi-cycle RV32I/RV64I control FSM.
// The package also holds the opcode decoder used by the top-level FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_BR       = 4'd2,
        S_JAL      = 4'd3,
        S_JALR     = 4'd4,
        S_R_EX     = 4'd5,
        S_I_EX     = 4'd6,
        S_WB_ALU   = 4'd7,
        S_LUI      = 4'd8,
        S_AUIPC    = 4'd9,
        S_MEM_ADDR = 4'd10,
        S_LOAD     = 4'd11,
        S_STORE    = 4'd12,
        S_LOAD_WB  = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_RTYPE = 3'd2,
        ALU_ITYPE = 3'd3
    } alu_op_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS1   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;
    localparam logic [1:0] M2R_IMM    = 2'd3;

    // Execute state selected from DECODE; S_TRAP flags an unknown opcode.
    function automatic state_e decode_opcode(input logic [6:0] op, input logic en_ui);
        state_e nxt;
        case (op)
            OP_BRANCH: nxt = S_BR;
            OP_JAL:    nxt = S_JAL;
            OP_JALR:   nxt = S_JALR;
            OP_RTYPE:  nxt = S_R_EX;
            OP_ITYPE:  nxt = S_I_EX;
            OP_LOAD:   nxt = S_MEM_ADDR;
            OP_STORE:  nxt = S_MEM_ADDR;
            OP_LUI:    nxt = en_ui ? S_LUI : S_TRAP;
            OP_AUIPC:  nxt = en_ui ? S_AUIPC : S_TRAP;
            default:   nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_controller_hs_if.sv
// Decode-field, branch-flag, memory handshake and datapath-control bundle
// between the controller (slave side) and its environment (master side).
interface mc_controller_hs_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [2:0] mem_funct;
    logic       trap;
    logic       bus_err;
    logic       illegal;

    modport slave (
        input  opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, mem_funct,
               trap, bus_err, illegal
    );

    modport master (
        output opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, mem_funct,
               trap, bus_err, illegal
    );
endinterface

// File: rtl/mc_controller_hs_branch_cond.sv
// Branch-condition evaluator: funct3 selects the comparison; funct3 010/011
// are not branches and are reported as bad_funct.
module mc_branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_o,
    output logic       bad_funct_o
);

    // Condition select; a bad encoding never reports taken.
    always_comb begin
        taken_o     = 1'b0;
        bad_funct_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = zero_i;
            F3_BNE:  taken_o = ~zero_i;
            F3_BLT:  taken_o = lt_i;
            F3_BGE:  taken_o = ~lt_i;
            F3_BLTU: taken_o = ltu_i;
            F3_BGEU: taken_o = ~ltu_i;
            default: bad_funct_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller_hs.sv
// Multi-cycle RISC-V control FSM with ready/valid memory handshake, timeout
// and a sticky trap state for bus errors and illegal instructions.
module mc_controller_hs
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT     = 15,
    parameter int unsigned WAIT_W       = 8,
    parameter bit          EN_LUI_AUIPC = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mc_controller_hs_if.slave   ctrl
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT_C = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_ONE_C = WAIT_W'(1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              illegal_q, illegal_d;

    logic       mem_wait_s;
    logic       timeout_s;
    logic       taken_s;
    logic       bad_funct_s;
    logic       pc_en_s, iord_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, pc_src_s, mem_to_reg_s;
    alu_op_e    alu_op_s;
    logic [2:0] mem_funct_s;
    logic       trap_s;
    logic       unused_funct7_s;

    // funct7_5 is consumed only by the external ALU controller.
    assign unused_funct7_s = ctrl.funct7_5;
    assign timeout_s       = (wait_cnt_q == MAX_WAIT_C);

    mc_branch_cond u_branch_cond (
        .funct3_i    (ctrl.funct3),
        .zero_i      (ctrl.zero),
        .lt_i        (ctrl.lt),
        .ltu_i       (ctrl.ltu),
        .taken_o     (taken_s),
        .bad_funct_o (bad_funct_s)
    );

    // Next-state, sticky-cause and datapath-control decode.
    always_comb begin
        state_d      = state_q;
        bus_err_d    = bus_err_q;
        illegal_d    = illegal_q;
        mem_wait_s   = 1'b0;
        pc_en_s      = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = SRC_A_PC;
        alu_src_b_s  = SRC_B_RS2;
        alu_op_s     = ALU_ADD;
        pc_src_s     = PC_SRC_ALU;
        mem_to_reg_s = M2R_ALUOUT;
        mem_funct_s  = 3'b000;
        trap_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = SRC_B_FOUR;
                mem_wait_s  = 1'b1;
                if (ctrl.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_en_s    = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
                state_d     = decode_opcode(ctrl.opcode, EN_LUI_AUIPC);
                if (state_d == S_TRAP) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            S_BR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_RS2;
                alu_op_s    = ALU_SUB;
                pc_src_s    = PC_SRC_ALUOUT;
                pc_en_s     = taken_s & ~bad_funct_s;
                if (bad_funct_s) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_JAL: begin
                mem_to_reg_s = M2R_PC;
                reg_write_s  = 1'b1;
                pc_src_s     = PC_SRC_ALUOUT;
                pc_en_s      = 1'b1;
                state_d      = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_IMM;
                pc_src_s     = PC_SRC_JALR;
                mem_to_reg_s = M2R_PC;
                reg_write_s  = 1'b1;
                pc_en_s      = 1'b1;
                state_d      = S_FETCH;
            end
            S_R_EX: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_RS2;
                alu_op_s    = ALU_RTYPE;
                state_d     = S_WB_ALU;
            end
            S_I_EX: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                alu_op_s    = ALU_ITYPE;
                state_d     = S_WB_ALU;
            end
            S_WB_ALU: begin
                mem_to_reg_s = M2R_ALUOUT;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_LUI: begin
                mem_to_reg_s = M2R_IMM;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
                state_d     = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                state_d     = (ctrl.opcode == OP_LOAD) ? S_LOAD : S_STORE;
            end
            S_LOAD: begin
                iord_s      = 1'b1;
                mem_read_s  = 1'b1;
                mem_funct_s = ctrl.funct3;
                mem_wait_s  = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = S_LOAD_WB;
                end else if (timeout_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_STORE: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                mem_funct_s = ctrl.funct3;
                mem_wait_s  = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_STORE;
                end
            end
            S_LOAD_WB: begin
                mem_to_reg_s = M2R_MDR;
                reg_write_s  = 1'b1;
                mem_funct_s  = ctrl.funct3;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                trap_s  = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                // Corrupted state encoding: park safely in TRAP.
                state_d   = S_TRAP;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Wait counter: runs only while an access stalls, cleared on any state change.
    always_comb begin
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_wait_s && !ctrl.mem_ready && (wait_cnt_q != WAIT_SAT_C)) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE_C;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State, wait counter and sticky trap-cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ctrl.pc_en      = pc_en_s;
    assign ctrl.iord       = iord_s;
    assign ctrl.mem_read   = mem_read_s;
    assign ctrl.mem_write  = mem_write_s;
    assign ctrl.ir_write   = ir_write_s;
    assign ctrl.reg_write  = reg_write_s;
    assign ctrl.alu_src_a  = alu_src_a_s;
    assign ctrl.alu_src_b  = alu_src_b_s;
    assign ctrl.alu_op     = alu_op_s;
    assign ctrl.pc_src     = pc_src_s;
    assign ctrl.mem_to_reg = mem_to_reg_s;
    assign ctrl.mem_funct  = mem_funct_s;
    assign ctrl.trap       = trap_s;
    assign ctrl.bus_err    = bus_err_q;
    assign ctrl.illegal    = illegal_q;

endmodule

// File: doc/mc_controller_hs.md
Name: mc_controller_hs

Overview:
- Next-generation multi-cycle RISC-V (RV32I/RV64I subset) control FSM. It drives the shared datapath: PC, instruction register, register file, ALU muxes, memory-data register.
- Beyond the current controller it adds:
  - a ready/valid memory handshake with a parametrised timeout;
  - the full branch-condition set (beq/bne/blt/bge/bltu/bgeu);
  - lui/auipc;
  - an illegal-opcode / bus-error trap state.
- It sits between the instruction register decode fields and the datapath/memory port.

Parameters:
- MAX_WAIT, 15, max cycles a memory access may wait for mem_ready before bus error (1..255)
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT
- EN_LUI_AUIPC, 1, when 0 the lui/auipc opcodes decode as illegal

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU result == 0
- lt  in  1  signed A<B
- ltu  in  1  unsigned A<B
- mem_ready  in  1  memory completes current access this cycle
- pc_en  out  1  PC write enable
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  read request
- mem_write  out  1  write request
- ir_write  out  1  IR load
- reg_write  out  1  register-file write
- alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old PC
- alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = imm
- alu_op  out  3  ALU-control class (package enum)
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link), 3 = imm
- mem_funct  out  3  funct3 forwarded during LOAD/STORE/LOAD_WB, else 0
- trap  out  1  FSM in TRAP
- bus_err  out  1  sticky: trap cause was a memory timeout
- illegal  out  1  sticky: trap cause was an unknown opcode

Behaviour:
- Reset:
  - state = FETCH, wait_cnt = 0, bus_err = 0, illegal = 0.
  - Outputs take FETCH values: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD; all other enables 0.
  - rst wins over every transition, including from TRAP and mid-wait.
- Outputs are combinational from state, plus mem_ready and the branch flags where noted. No output is registered except the sticky flags.
- FETCH:
  - mem_read = 1.
  - If mem_ready: ir_write = 1, pc_en = 1 (PC ← PC+4), go to DECODE, clear wait_cnt.
  - Else wait_cnt++.
  - If wait_cnt == MAX_WAIT and !mem_ready: go to TRAP, set bus_err.
- DECODE:
  - alu_src_a = 2, alu_src_b = 2, alu_op = ADD (branch target → ALUOut).
  - Next state by opcode:
    - 1100011 → BR
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110011 → R_EX
    - 0010011 → I_EX
    - 0000011 / 0100011 → MEM_ADDR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → TRAP, set illegal.
- BR:
  - alu_src_a = 1, alu_src_b = 0, alu_op = SUB, pc_src = 1.
  - pc_en = taken, where taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011 → TRAP + illegal, with pc_en = 0.
  - Otherwise → FETCH.
- JAL: mem_to_reg = 2, reg_write = 1, pc_src = 1, pc_en = 1 → FETCH.
- JALR: alu_src_a = 1, alu_src_b = 2, alu_op = ADD, pc_src = 2, mem_to_reg = 2, reg_write = 1, pc_en = 1 → FETCH.
- R_EX: alu_src_a = 1, alu_src_b = 0, alu_op = RTYPE → WB_ALU.
- I_EX: alu_src_a = 1, alu_src_b = 2, alu_op = ITYPE → WB_ALU.
- WB_ALU: mem_to_reg = 0, reg_write = 1 → FETCH.
- LUI: mem_to_reg = 3, reg_write = 1 → FETCH.
- AUIPC: alu_src_a = 2, alu_src_b = 2, alu_op = ADD → WB_ALU.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = ADD → LOAD (opcode 0000011) or STORE.
- LOAD:
  - iord = 1, mem_read = 1, mem_funct = funct3.
  - Same wait/timeout rule as FETCH. On mem_ready → LOAD_WB.
- STORE:
  - iord = 1, mem_write = 1, mem_funct = funct3.
  - mem_write is held until mem_ready, then → FETCH. Same timeout rule.
- LOAD_WB: mem_to_reg = 1, reg_write = 1, mem_funct = funct3 → FETCH.
- TRAP:
  - All enables 0, trap = 1.
  - Held until rst. bus_err and illegal stay stable.
- wait_cnt:
  - Counts only in FETCH/LOAD/STORE while !mem_ready.
  - Cleared on every state change.
  - Saturates; never wraps.
- mem_ready outside FETCH/LOAD/STORE is ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (15 states, 4-bit encoding);
  - opcode constants;
  - alu_op enum: ADD = 0, SUB = 1, RTYPE = 2, ITYPE = 3;
  - pc_src, mem_to_reg and alu_src_a/b select constants.
- One sub-module, mc_branch_cond: (funct3, zero, lt, ltu) → (taken, bad_funct).
- The existing alu_controller stays external; it consumes alu_op together with the funct fields.

Test Plan:
- add x3,x1,x2 with mem_ready = 1 every cycle → states FETCH, DECODE, R_EX, WB_ALU, FETCH. reg_write = 1 only in cycle 4; pc_en = 1 only in cycle 1.
- lw with mem_ready delayed 3 cycles in LOAD → LOAD held 4 cycles with mem_read = 1, iord = 1 and mem_funct = 010, then LOAD_WB with mem_to_reg = 1.
- Fetch with mem_ready stuck 0 and MAX_WAIT = 15 → after 16 FETCH cycles the FSM enters TRAP, with trap = 1 and bus_err = 1. Assert rst for 1 cycle → FETCH, bus_err = 0.
- bne (funct3 001) with zero = 0 → pc_en = 1, pc_src = 1 in BR. Same instruction with zero = 1 → pc_en = 0.
- bgeu with ltu = 1 → pc_en = 0; blt with lt = 1 → pc_en = 1.
- opcode 1111111 → TRAP with illegal = 1. Repeat with EN_LUI_AUIPC = 0 and opcode 0110111 → TRAP with illegal = 1.
